fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Controller that owns the program counter and drives the InstructionFetch stage's pc and flush inputs. It sequences sequential fetch (PC+4), holds the PC on hazard stalls, and redirects on taken branches or jumps resolved downstream. On each redirect it squashes the wrong-path instructions already in flight. It sits between the hazard/branch logic and InstructionFetch in the five-stage pipeline.

Parameters:
PC_WIDTH, 6, width of pc and redirect_pc; matches the InstructionFetch pc port.
RESET_PC, 0, PC value loaded on reset; must be a multiple of 4.
FLUSH_CYCLES, 2, number of cycles flush is held after a redirect; legal range 1..7.

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  hazard unit request to hold the PC this cycle
redirect_valid  input  1  taken branch or jump resolved this cycle
redirect_pc  input  PC_WIDTH  target address, sampled when redirect_valid=1
pc  output  PC_WIDTH  fetch address to InstructionFetch (registered)
flush  output  1  squash to InstructionFetch (registered)
if_valid  output  1  the instruction fetched this cycle is on the correct path (registered)
busy_flush  output  1  state == FLUSH (registered)
misalign_err  output  1  sticky flag: a redirect target had bits [1:0] != 0

Behaviour:
- Reset (asynchronous assert, any time, including mid-FLUSH):
  - pc=RESET_PC, flush=1, if_valid=0, busy_flush=0, misalign_err=0.
  - State = BOOT, flush counter = 0.
- States: BOOT, RUN, FLUSH; 2-bit encoding.
- BOOT: lasts exactly one clock edge after reset deasserts.
  - That edge: flush<=0, if_valid<=1, state<=RUN.
  - pc stays RESET_PC, so the first valid fetch is RESET_PC.
- RUN, evaluated at each rising edge, in priority order:
  1. redirect_valid=1: pc<={redirect_pc[PC_WIDTH-1:2],2'b00}, flush<=1, if_valid<=0, counter<=FLUSH_CYCLES-1, state<=FLUSH. If redirect_pc[1:0]!=0, misalign_err<=1.
  2. stall=1: pc, flush and if_valid hold.
  3. Otherwise: pc<=pc+4, modulo 2^PC_WIDTH (0x3C wraps to 0x00 at PC_WIDTH=6); flush<=0; if_valid<=1.
- Redirect has priority over stall. A redirect that arrives during a stall is never lost.
- FLUSH:
  - flush=1 and if_valid=0 for exactly FLUSH_CYCLES cycles after the redirect edge (no stall).
  - PC sequencing is the same as RUN: pc+4 if no stall, hold if stall.
  - Counter decrements only on non-stalled edges, so a stall extends the flush window.
  - When counter==0 on a non-stalled edge: flush<=0, if_valid<=1, state<=RUN.
  - A new redirect_valid in FLUSH reloads pc and sets counter<=FLUSH_CYCLES-1 (restart).
- busy_flush mirrors state==FLUSH.
- misalign_err is cleared only by reset.
- All outputs come directly from flops; no combinational input-to-output paths.
- The PC adder is internal. The pc_plus_4 output of InstructionFetch is not consumed.

Decomposition:
- Shared pipeline package holds:
  - the fetch_state_t enum (BOOT/RUN/FLUSH);
  - the PC_WIDTH default;
  - the INSTR_BYTES=4 constant.
- No sub-module: one FSM plus the PC register, a 3-bit counter, and the sticky flag.
- The integration top instantiates fetch_sequencer beside InstructionFetch, wiring pc->pc and flush->flush.

Test Plan:
- Reset then release, no stall/redirect -> pc sequence 0x00(BOOT), 0x00, 0x04, 0x08, 0x0C on successive edges; flush drops after 1 edge; if_valid=1 from RUN on.
- Free-run from 0x38 -> 0x38, 0x3C, 0x00, 0x04 (wrap); if_valid stays 1.
- In RUN at pc=0x08, redirect_valid=1 with redirect_pc=0x20 -> next pc=0x20 with flush=1, busy_flush=1; flush=1 for 2 cycles (pc 0x20, 0x24); then pc=0x28 with flush=0, if_valid=1.
- stall=1 and redirect_valid=1 on the same edge (redirect_pc=0x10) -> redirect wins: pc=0x10, FLUSH entered. A stall during FLUSH holds pc and extends flush by the stalled cycles.
- Redirect to 0x12 -> pc=0x10, misalign_err=1, and it stays 1 through later redirects until reset.
- Assert reset asynchronously mid-FLUSH (between edges) -> pc=0x00, flush=1, if_valid=0, busy_flush=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_pkg
// Description : Shared fetch types and constants for the PC sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_sequencer_pkg;

    localparam int c_PC_WIDTH_DEFAULT = 6;
    localparam int c_INSTR_BYTES      = 4;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_t;

endpackage : fetch_sequencer_pkg
`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_if
// Description : Hazard/branch-side controls and fetch-side outputs of the PC sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_WIDTH = c_PC_WIDTH_DEFAULT
) ();

    logic                stall;
    logic                redirect_valid;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic [PC_WIDTH-1:0] pc;
    logic                flush;
    logic                if_valid;
    logic                busy_flush;
    logic                misalign_err;

    // master: hazard/branch logic side; slave: the sequencer itself
    modport master (
        output stall, redirect_valid, redirect_pc,
        input  pc, flush, if_valid, busy_flush, misalign_err
    );

    modport slave (
        input  stall, redirect_valid, redirect_pc,
        output pc, flush, if_valid, busy_flush, misalign_err
    );

endinterface : fetch_sequencer_if
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Owns the PC: sequential fetch, stall hold, redirect with flush window.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_WIDTH     = c_PC_WIDTH_DEFAULT,
    parameter int RESET_PC     = 0,
    parameter int FLUSH_CYCLES = 2
) (
    input  wire logic        clk,
    input  wire logic        reset,
    fetch_sequencer_if.slave bus
);

    localparam logic [PC_WIDTH-1:0] c_RESET_PC     = PC_WIDTH'(RESET_PC);
    localparam logic [PC_WIDTH-1:0] c_PC_STEP      = PC_WIDTH'(c_INSTR_BYTES);
    localparam logic [2:0]          c_FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    fetch_state_t        r_state;
    logic [2:0]          r_flush_cnt;
    logic [PC_WIDTH-1:0] r_pc;
    logic                r_flush;
    logic                r_if_valid;
    logic                r_busy_flush;
    logic                r_misalign_err;

    logic [PC_WIDTH-1:0] w_redirect_aligned;
    logic                w_redirect_misaligned;

    assign w_redirect_aligned    = {bus.redirect_pc[PC_WIDTH-1:2], 2'b00};
    assign w_redirect_misaligned = |bus.redirect_pc[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_BOOT;
            r_flush_cnt    <= 3'd0;
            r_pc           <= c_RESET_PC;
            r_flush        <= 1'b1;
            r_if_valid     <= 1'b0;
            r_busy_flush   <= 1'b0;
            r_misalign_err <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    // PC is not advanced here so RESET_PC is the first valid fetch
                    r_flush    <= 1'b0;
                    r_if_valid <= 1'b1;
                    r_state    <= ST_RUN;
                end

                ST_RUN, ST_FLUSH: begin
                    if (bus.redirect_valid) begin
                        r_pc         <= w_redirect_aligned;
                        r_flush      <= 1'b1;
                        r_if_valid   <= 1'b0;
                        r_flush_cnt  <= c_FLUSH_RELOAD;
                        r_busy_flush <= 1'b1;
                        r_state      <= ST_FLUSH;
                        if (w_redirect_misaligned) begin
                            r_misalign_err <= 1'b1;
                        end
                    end else if (!bus.stall) begin
                        r_pc <= r_pc + c_PC_STEP;
                        if (r_state == ST_RUN) begin
                            r_flush    <= 1'b0;
                            r_if_valid <= 1'b1;
                        end else if (r_flush_cnt == 3'd0) begin
                            r_flush      <= 1'b0;
                            r_if_valid   <= 1'b1;
                            r_busy_flush <= 1'b0;
                            r_state      <= ST_RUN;
                        end else begin
                            r_flush_cnt <= r_flush_cnt - 3'd1;
                        end
                    end
                end

                default: begin
                    // Unreachable encoding: recover through a clean boot
                    r_state      <= ST_BOOT;
                    r_flush_cnt  <= 3'd0;
                    r_flush      <= 1'b1;
                    r_if_valid   <= 1'b0;
                    r_busy_flush <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc           = r_pc;
    assign bus.flush        = r_flush;
    assign bus.if_valid     = r_if_valid;
    assign bus.busy_flush   = r_busy_flush;
    assign bus.misalign_err = r_misalign_err;

endmodule : fetch_sequencer
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Directed self-checking bench for fetch_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    fetch_sequencer_if #(.PC_WIDTH(6)) bus ();

    fetch_sequencer #(
        .PC_WIDTH     (6),
        .RESET_PC     (0),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [5:0] pc, input logic fl,
                              input logic iv, input logic bz, input logic me);
        chk({tag, ".pc"},       32'(bus.pc),           32'(pc));
        chk({tag, ".flush"},    32'(bus.flush),        32'(fl));
        chk({tag, ".if_valid"}, 32'(bus.if_valid),     32'(iv));
        chk({tag, ".busy"},     32'(bus.busy_flush),   32'(bz));
        chk({tag, ".misalign"}, 32'(bus.misalign_err), 32'(me));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic redirect(input logic [5:0] target, input logic stl);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        bus.stall          = stl;
        step();
        bus.redirect_valid = 1'b0;
        bus.stall          = 1'b0;
    endtask

    initial begin
        total              = 0;
        bad                = 0;
        reset              = 1'b1;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        step();
        step();
        expect_out("reset", 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        reset = 1'b0;
        step();
        expect_out("boot", 6'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        expect_out("seq1", 6'h04, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        expect_out("seq2", 6'h08, 1'b0, 1'b1, 1'b0, 1'b0);

        redirect(6'h20, 1'b0);
        expect_out("redir0", 6'h20, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        expect_out("redir1", 6'h24, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        expect_out("redir2", 6'h28, 1'b0, 1'b1, 1'b0, 1'b0);

        // Land on 0x38 with if_valid high, then run through the wrap
        redirect(6'h30, 1'b0);
        step();
        step();
        expect_out("wrap38", 6'h38, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        expect_out("wrap3c", 6'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        expect_out("wrap00", 6'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        expect_out("wrap04", 6'h04, 1'b0, 1'b1, 1'b0, 1'b0);

        redirect(6'h10, 1'b1);
        expect_out("stlred", 6'h10, 1'b1, 1'b0, 1'b1, 1'b0);
        bus.stall = 1'b1;
        step();
        expect_out("fstall1", 6'h10, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        expect_out("fstall2", 6'h10, 1'b1, 1'b0, 1'b1, 1'b0);
        bus.stall = 1'b0;
        step();
        expect_out("fresume", 6'h14, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        expect_out("fexit", 6'h18, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.stall = 1'b1;
        step();
        expect_out("rstall", 6'h18, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.stall = 1'b0;

        redirect(6'h12, 1'b0);
        expect_out("misal", 6'h10, 1'b1, 1'b0, 1'b1, 1'b1);
        redirect(6'h20, 1'b0);
        expect_out("restart0", 6'h20, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        expect_out("restart1", 6'h24, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        expect_out("restart2", 6'h28, 1'b0, 1'b1, 1'b0, 1'b1);

        redirect(6'h08, 1'b0);
        expect_out("preasync", 6'h08, 1'b1, 1'b0, 1'b1, 1'b1);
        #2 reset = 1'b1;
        #1;
        expect_out("async", 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step();
        expect_out("reboot", 6'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        expect_out("reseq", 6'h04, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fetch_sequencer
`default_nettype wire
